// File: rtl/cpu_pkg.sv
// Shared definitions for the interrupt controller: register map, FSM encoding,
// channel mode encoding and a Wishbone byte-lane helper.
package cpu_pkg;

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_ENABLE  = 2'd1;
   localparam logic [1:0] REG_MODE    = 2'd2;
   localparam logic [1:0] REG_STATUS  = 2'd3;

   localparam logic MODE_LEVEL = 1'b0;
   localparam logic MODE_EDGE  = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      ACTIVE = 2'd2
   } state_e;

   function automatic logic [31:0] byte_mask(input logic [3:0] sel);
      return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One request channel: two-flop synchroniser followed by a previous-value flop,
// giving the synchronised level and a one-cycle rising-edge pulse.
module irq_sync_edge (
   input  logic clk,
   input  logic rst_n_i,
   input  logic irq_i,
   output logic level_o,
   output logic rise_o
);

   logic s1_q;
   logic s2_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         s1_q   <= irq_i;
         s2_q   <= s1_q;
         prev_q <= s2_q;
      end
   end

   assign level_o = s2_q;
   assign rise_o  = s2_q & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Parametrised interrupt controller: per-channel enable and edge/level mode,
// highest-index-wins arbitration, single CPU request with vector, Wishbone slave.
module irq_ctrl
   import cpu_pkg::*;
#(
   parameter int          NUM_IRQ    = 8,
   parameter logic [31:0] VEC_BASE   = 32'h0000_0004,
   parameter int          VEC_STRIDE = 4
) (
   input  logic               clk,
   input  logic               rst_n_i,
   input  logic [NUM_IRQ-1:0] irq_i,
   output logic               irq_o,
   output logic [31:0]        vec_o,
   input  logic               irq_ack_i,
   input  logic               eoi_i,
   input  logic               stb_i,
   input  logic               we_i,
   input  logic [3:0]         adr_i,
   input  logic [31:0]        dat_i,
   input  logic [3:0]         sel_i,
   output logic [31:0]        dat_o,
   output logic               ack_o
);

   logic [NUM_IRQ-1:0] lvl;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] pend_q, pend_d;
   logic [NUM_IRQ-1:0] en_q, en_d;
   logic [NUM_IRQ-1:0] mode_q, mode_d;
   logic [NUM_IRQ-1:0] req;
   logic [NUM_IRQ-1:0] w1c;
   logic [NUM_IRQ-1:0] ack_clr;
   logic [NUM_IRQ-1:0] idx_onehot;
   logic [NUM_IRQ-1:0] w_sel;
   logic [NUM_IRQ-1:0] w_dat;
   logic               latched_req;

   state_e      state_q, state_d;
   logic [4:0]  idx_q, idx_d;
   logic [4:0]  sel_idx;
   logic        irq_q, irq_d;
   logic [31:0] vec_q, vec_d;
   logic        ack_q;
   logic [31:0] dat_q, dat_d;
   logic [31:0] wmask;
   logic [31:0] rd_data;
   logic        bus_go;
   logic        wr_go;
   logic        unused_sink;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_chan
      irq_sync_edge u_sync (
         .clk     (clk),
         .rst_n_i (rst_n_i),
         .irq_i   (irq_i[g]),
         .level_o (lvl[g]),
         .rise_o  (rise[g])
      );
   end

   // A transfer is accepted on the edge that raises ack; writes commit on that same edge.
   assign bus_go = stb_i & ~ack_q;
   assign wr_go  = bus_go & we_i;
   assign wmask  = byte_mask(sel_i);
   assign w_sel  = wmask[NUM_IRQ-1:0];
   assign w_dat  = dat_i[NUM_IRQ-1:0];
   assign unused_sink = ^{adr_i[1:0], wmask, dat_i};

   always_comb begin
      en_d   = en_q;
      mode_d = mode_q;
      w1c    = '0;
      if (wr_go) begin
         case (adr_i[3:2])
            REG_PENDING: w1c    = w_dat & w_sel;
            REG_ENABLE:  en_d   = (en_q & ~w_sel) | (w_dat & w_sel);
            REG_MODE:    mode_d = (mode_q & ~w_sel) | (w_dat & w_sel);
            default:     ;
         endcase
      end
   end

   // Edge channels: a new rising edge beats both W1C and the acknowledge clear.
   always_comb begin
      pend_d = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (mode_q[i] == MODE_EDGE) begin
            pend_d[i] = (pend_q[i] & ~w1c[i] & ~ack_clr[i]) | rise[i];
         end else begin
            pend_d[i] = lvl[i];
         end
      end
   end

   assign req = pend_q & en_q;

   always_comb begin
      sel_idx    = '0;
      idx_onehot = '0;
      for (int i = 0; i < NUM_IRQ; i++) begin
         if (req[i]) begin
            sel_idx = 5'(i);
         end
         idx_onehot[i] = (idx_q == 5'(i));
      end
   end

   assign latched_req = |(req & idx_onehot);

   always_comb begin
      rd_data = '0;
      case (adr_i[3:2])
         REG_PENDING: rd_data[NUM_IRQ-1:0] = pend_q;
         REG_ENABLE:  rd_data[NUM_IRQ-1:0] = en_q;
         REG_MODE:    rd_data[NUM_IRQ-1:0] = mode_q;
         default: begin
            if (state_q == ACTIVE) begin
               rd_data[31]  = 1'b1;
               rd_data[4:0] = idx_q;
            end
         end
      endcase
      dat_d = (bus_go && !we_i) ? rd_data : '0;
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      vec_d   = vec_q;
      irq_d   = irq_q;
      ack_clr = '0;
      case (state_q)
         IDLE: begin
            irq_d = 1'b0;
            if (|req) begin
               idx_d   = sel_idx;
               vec_d   = VEC_BASE + 32'(sel_idx) * 32'(VEC_STRIDE);
               irq_d   = 1'b1;
               state_d = ASSERT;
            end
         end
         ASSERT: begin
            // The vector stays locked to the latched channel; a withdrawn request re-arbitrates.
            if (irq_ack_i) begin
               ack_clr = idx_onehot & mode_q;
               irq_d   = 1'b0;
               state_d = ACTIVE;
            end else if (!latched_req) begin
               irq_d   = 1'b0;
               state_d = IDLE;
            end
         end
         ACTIVE: begin
            irq_d = 1'b0;
            if (eoi_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            irq_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n_i) begin
         pend_q  <= '0;
         en_q    <= '0;
         mode_q  <= '0;
         state_q <= IDLE;
         idx_q   <= '0;
         irq_q   <= 1'b0;
         vec_q   <= VEC_BASE;
         ack_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         pend_q  <= pend_d;
         en_q    <= en_d;
         mode_q  <= mode_d;
         state_q <= state_d;
         idx_q   <= idx_d;
         irq_q   <= irq_d;
         vec_q   <= vec_d;
         ack_q   <= bus_go;
         dat_q   <= dat_d;
      end
   end

   assign irq_o = irq_q;
   assign vec_o = vec_q;
   assign ack_o = ack_q;
   assign dat_o = dat_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl built with three channels: register table plus
// hand-timed sequences for latency, priority, level re-assert, W1C races and reset.
module tb_irq_ctrl;

   localparam int N = 3;

   logic          clk;
   logic          rst_n_i;
   logic [N-1:0]  irq_i;
   logic          irq_o;
   logic [31:0]   vec_o;
   logic          irq_ack_i;
   logic          eoi_i;
   logic          stb_i;
   logic          we_i;
   logic [3:0]    adr_i;
   logic [31:0]   dat_i;
   logic [3:0]    sel_i;
   logic [31:0]   dat_o;
   logic          ack_o;

   int passed = 0;
   int total  = 0;

   typedef struct {
      logic        do_wr;
      logic [1:0]  rg;
      logic [31:0] wdat;
      logic [3:0]  sel;
      logic [31:0] exp;
   } reg_vec_t;

   reg_vec_t tbl [12];

   irq_ctrl #(
      .NUM_IRQ    (N),
      .VEC_BASE   (32'h0000_0004),
      .VEC_STRIDE (4)
   ) dut (
      .clk       (clk),
      .rst_n_i   (rst_n_i),
      .irq_i     (irq_i),
      .irq_o     (irq_o),
      .vec_o     (vec_o),
      .irq_ack_i (irq_ack_i),
      .eoi_i     (eoi_i),
      .stb_i     (stb_i),
      .we_i      (we_i),
      .adr_i     (adr_i),
      .dat_i     (dat_i),
      .sel_i     (sel_i),
      .dat_o     (dat_o),
      .ack_o     (ack_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h, required %h", nm, act, exp);
   endtask

   task automatic bus(input logic we, input logic [1:0] rg, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd);
      stb_i = 1'b1; we_i = we; adr_i = {rg, 2'b00}; dat_i = d; sel_i = s;
      tick();
      chk("ack_hi", {31'b0, ack_o}, 32'd1);
      rd = dat_o;
      stb_i = 1'b0; we_i = 1'b0; dat_i = '0; sel_i = '0;
      tick();
      chk("ack_lo", {31'b0, ack_o}, 32'd0);
   endtask

   task automatic wr(input logic [1:0] rg, input logic [31:0] d);
      logic [31:0] dummy;
      bus(1'b1, rg, d, 4'hF, dummy);
   endtask

   task automatic rd_chk(input string nm, input logic [1:0] rg, input logic [31:0] exp);
      logic [31:0] v;
      bus(1'b0, rg, 32'h0, 4'h0, v);
      chk(nm, v, exp);
   endtask

   task automatic pulse_ack();
      irq_ack_i = 1'b1; tick(); irq_ack_i = 1'b0;
   endtask

   task automatic pulse_eoi();
      eoi_i = 1'b1; tick(); eoi_i = 1'b0;
   endtask

   initial begin
      logic [31:0] v;
      rst_n_i = 1'b0; irq_i = '0; irq_ack_i = 1'b0; eoi_i = 1'b0;
      stb_i = 1'b0; we_i = 1'b0; adr_i = '0; dat_i = '0; sel_i = '0;

      tbl[0]  = '{1'b0, 2'd0, 32'h0,         4'h0, 32'h0};
      tbl[1]  = '{1'b0, 2'd1, 32'h0,         4'h0, 32'h0};
      tbl[2]  = '{1'b0, 2'd2, 32'h0,         4'h0, 32'h0};
      tbl[3]  = '{1'b0, 2'd3, 32'h0,         4'h0, 32'h0};
      tbl[4]  = '{1'b1, 2'd1, 32'hFFFF_FFFF, 4'hF, 32'h7};
      tbl[5]  = '{1'b1, 2'd1, 32'h0,         4'hE, 32'h7};
      tbl[6]  = '{1'b1, 2'd1, 32'h0,         4'h1, 32'h0};
      tbl[7]  = '{1'b1, 2'd2, 32'h5,         4'hF, 32'h5};
      tbl[8]  = '{1'b1, 2'd2, 32'hFFFF_FF02, 4'hE, 32'h5};
      tbl[9]  = '{1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, 32'h0};
      tbl[10] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 4'hF, 32'h0};
      tbl[11] = '{1'b1, 2'd1, 32'h0000_0005, 4'h1, 32'h5};

      ticks(2);
      chk("rst_irq", {31'b0, irq_o}, 32'd0);
      chk("rst_vec", vec_o, 32'h4);
      chk("rst_ack", {31'b0, ack_o}, 32'd0);
      chk("rst_dat", dat_o, 32'h0);
      rst_n_i = 1'b1;
      tick();

      // Register table: optional write, then read-back of the same register.
      for (int i = 0; i < 12; i++) begin
         if (tbl[i].do_wr) bus(1'b1, tbl[i].rg, tbl[i].wdat, tbl[i].sel, v);
         bus(1'b0, tbl[i].rg, 32'h0, 4'h0, v);
         chk($sformatf("tbl%0d", i), v, tbl[i].exp);
      end

      // Edge channel 2: latency, ack clear, STATUS, eoi.
      irq_i[2] = 1'b1; tick(); irq_i[2] = 1'b0;
      ticks(2);
      chk("lat_irq_n2", {31'b0, irq_o}, 32'd0);
      tick();
      chk("lat_irq_n3", {31'b0, irq_o}, 32'd1);
      chk("lat_vec_n3", vec_o, 32'h0C);
      rd_chk("pend_assert", 2'd0, 32'h4);
      pulse_ack();
      chk("ack_irq_lo", {31'b0, irq_o}, 32'd0);
      rd_chk("pend_acked", 2'd0, 32'h0);
      rd_chk("status_act", 2'd3, 32'h8000_0002);
      pulse_eoi();
      rd_chk("status_idle", 2'd3, 32'h0);

      // Channels 0 and 2 together; then a higher arrival during ASSERT.
      irq_i = 3'b101; tick(); irq_i = '0;
      ticks(3);
      chk("prio_irq", {31'b0, irq_o}, 32'd1);
      chk("prio_vec", vec_o, 32'h0C);
      pulse_ack();
      pulse_eoi();
      chk("eoi_irq_lo", {31'b0, irq_o}, 32'd0);
      tick();
      chk("second_irq", {31'b0, irq_o}, 32'd1);
      chk("second_vec", vec_o, 32'h04);
      irq_i[2] = 1'b1; tick(); irq_i[2] = 1'b0;
      ticks(3);
      chk("no_retarget_vec", vec_o, 32'h04);
      chk("no_retarget_irq", {31'b0, irq_o}, 32'd1);
      pulse_ack();
      pulse_eoi();
      tick();
      chk("late_hi_vec", vec_o, 32'h0C);
      chk("late_hi_irq", {31'b0, irq_o}, 32'd1);
      pulse_ack();
      pulse_eoi();
      tick();
      chk("drained_irq", {31'b0, irq_o}, 32'd0);
      rd_chk("drained_pend", 2'd0, 32'h0);

      // Level channel 1: re-assert after eoi, withdrawal during ASSERT.
      wr(2'd2, 32'h0);
      wr(2'd1, 32'h2);
      irq_i[1] = 1'b1;
      ticks(4);
      chk("lvl_irq", {31'b0, irq_o}, 32'd1);
      chk("lvl_vec", vec_o, 32'h08);
      pulse_ack();
      chk("lvl_ack_lo", {31'b0, irq_o}, 32'd0);
      rd_chk("lvl_status", 2'd3, 32'h8000_0001);
      pulse_eoi();
      chk("lvl_eoi_lo", {31'b0, irq_o}, 32'd0);
      tick();
      chk("lvl_reassert", {31'b0, irq_o}, 32'd1);
      irq_i[1] = 1'b0;
      ticks(4);
      chk("lvl_withdraw", {31'b0, irq_o}, 32'd0);
      rd_chk("lvl_wd_status", 2'd3, 32'h0);

      // W1C races with new set conditions.
      wr(2'd2, 32'h5);
      wr(2'd1, 32'h0);
      irq_i[0] = 1'b1; tick(); irq_i[0] = 1'b0;
      ticks(3);
      rd_chk("w1c_pre", 2'd0, 32'h1);
      irq_i[0] = 1'b1;
      ticks(2);
      wr(2'd0, 32'h1);
      irq_i[0] = 1'b0;
      rd_chk("w1c_vs_edge", 2'd0, 32'h1);
      wr(2'd0, 32'h1);
      rd_chk("w1c_plain", 2'd0, 32'h0);
      irq_i[1] = 1'b1;
      ticks(3);
      wr(2'd0, 32'h2);
      rd_chk("w1c_level", 2'd0, 32'h2);
      irq_i[1] = 1'b0;
      ticks(3);
      rd_chk("level_gone", 2'd0, 32'h0);

      // Reset while ACTIVE.
      wr(2'd1, 32'h4);
      irq_i[2] = 1'b1; tick(); irq_i[2] = 1'b0;
      ticks(3);
      chk("pre_rst_irq", {31'b0, irq_o}, 32'd1);
      pulse_ack();
      rd_chk("pre_rst_status", 2'd3, 32'h8000_0002);
      rst_n_i = 1'b0; tick(); rst_n_i = 1'b1;
      chk("midrst_irq", {31'b0, irq_o}, 32'd0);
      chk("midrst_vec", vec_o, 32'h4);
      rd_chk("midrst_status", 2'd3, 32'h0);
      rd_chk("midrst_enable", 2'd1, 32'h0);
      rd_chk("midrst_mode", 2'd2, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
